// File: rtl/openframe_gpio_cfg_loader.sv
// Pad-control loader for the openframe user area.
// A byte stream, one byte per pad, is written into a shadow bank. Once the
// last pad has its byte, the whole shadow bank is copied into the active bank
// in a single cycle, so the pads never show a half-written configuration.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | active config held, byte stream not accepted
//  S_LOAD  | accepting bytes into shadow[pad_index]
//  S_APPLY | single cycle: shadow copied to active, cfg_done raised next
module openframe_gpio_cfg_loader #(
   parameter int unsigned NUM_PADS  = 44,
   parameter logic [7:0]  RESET_CFG = 8'h02,
   localparam int unsigned IDX_W    = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 cfg_start_i,
   input  logic                 cfg_abort_i,
   input  logic                 wr_valid_i,
   output logic                 wr_ready_o,
   input  logic [7:0]           wr_data_i,
   output logic [IDX_W-1:0]     pad_index_o,
   output logic                 cfg_busy_o,
   output logic                 cfg_done_o,
   output logic [NUM_PADS-1:0]  gpio_oe_o,
   output logic [NUM_PADS-1:0]  gpio_ie_o,
   output logic [NUM_PADS-1:0]  gpio_schmitt_o,
   output logic [NUM_PADS-1:0]  gpio_slew_o,
   output logic [NUM_PADS-1:0]  gpio_pullup_o,
   output logic [NUM_PADS-1:0]  gpio_pulldown_o,
   output logic [NUM_PADS-1:0]  gpio_drive0_o,
   output logic [NUM_PADS-1:0]  gpio_drive1_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_APPLY = 2'd2
   } state_e;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PADS - 1);

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  pad_idx_q, pad_idx_d;
   logic              done_q;
   logic [7:0]        shadow_q [NUM_PADS];
   logic [7:0]        active_q [NUM_PADS];
   logic              accept;

   // Abort takes priority over a coincident byte, so the byte is refused.
   assign wr_ready_o  = (state_q == S_LOAD) && !cfg_abort_i;
   assign accept      = wr_valid_i && wr_ready_o;
   assign pad_index_o = pad_idx_q;
   assign cfg_busy_o  = (state_q == S_LOAD) || (state_q == S_APPLY);
   assign cfg_done_o  = done_q;

   // Next-state and pad index sequencing.
   always_comb begin
      state_d   = state_q;
      pad_idx_d = pad_idx_q;
      case (state_q)
         S_IDLE: begin
            if (cfg_start_i) begin
               state_d   = S_LOAD;
               pad_idx_d = '0;
            end
         end
         S_LOAD: begin
            if (cfg_abort_i) begin
               state_d   = S_IDLE;
               pad_idx_d = '0;
            end else if (accept) begin
               // Index parks on the last pad through APPLY rather than wrapping.
               if (pad_idx_q == LAST_IDX) state_d = S_APPLY;
               else                       pad_idx_d = pad_idx_q + IDX_W'(1);
            end
         end
         S_APPLY: begin
            state_d   = S_IDLE;
            pad_idx_d = '0;
         end
         default: begin
            state_d   = S_IDLE;
            pad_idx_d = '0;
         end
      endcase
   end

   // State, index and done-pulse registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         pad_idx_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pad_idx_q <= pad_idx_d;
         done_q    <= (state_q == S_APPLY);
      end
   end

   // Shadow bank takes stream bytes; active bank copies it whole in APPLY.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int p = 0; p < NUM_PADS; p++) begin
            shadow_q[p] <= RESET_CFG;
            active_q[p] <= RESET_CFG;
         end
      end else begin
         if (accept) shadow_q[pad_idx_q] <= wr_data_i;
         if (state_q == S_APPLY) begin
            for (int p = 0; p < NUM_PADS; p++) active_q[p] <= shadow_q[p];
         end
      end
   end

   // Fan active bytes out to the per-function pad buses.
   always_comb begin
      gpio_oe_o       = '0;
      gpio_ie_o       = '0;
      gpio_schmitt_o  = '0;
      gpio_slew_o     = '0;
      gpio_pullup_o   = '0;
      gpio_pulldown_o = '0;
      gpio_drive0_o   = '0;
      gpio_drive1_o   = '0;
      for (int p = 0; p < NUM_PADS; p++) begin
         gpio_oe_o[p]       = active_q[p][0];
         gpio_ie_o[p]       = active_q[p][1];
         gpio_schmitt_o[p]  = active_q[p][2];
         gpio_slew_o[p]     = active_q[p][3];
         gpio_pullup_o[p]   = active_q[p][4];
         gpio_pulldown_o[p] = active_q[p][5];
         gpio_drive0_o[p]   = active_q[p][6];
         gpio_drive1_o[p]   = active_q[p][7];
      end
   end

endmodule

// File: tb/tb_openframe_gpio_cfg_loader.sv
// Bench for openframe_gpio_cfg_loader: directed scenarios plus a random
// stream, with a transaction-level model compared every cycle.
module tb_openframe_gpio_cfg_loader;

   localparam int N = 44;
   localparam logic [7:0] RCFG = 8'h02;
   localparam logic [63:0] ALL1 = 64'hFFF_FFFF_FFFF;

   logic          clk = 1'b0;
   logic          reset, cfg_start, cfg_abort, wr_valid;
   logic [7:0]    wr_data;
   logic          wr_ready, cfg_busy, cfg_done;
   logic [5:0]    pad_index;
   logic [N-1:0]  g_oe, g_ie, g_sch, g_slew, g_pu, g_pd, g_d0, g_d1;

   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;

   openframe_gpio_cfg_loader #(.NUM_PADS(N), .RESET_CFG(RCFG)) dut (
      .clk_i(clk), .reset_i(reset), .cfg_start_i(cfg_start), .cfg_abort_i(cfg_abort),
      .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
      .pad_index_o(pad_index), .cfg_busy_o(cfg_busy), .cfg_done_o(cfg_done),
      .gpio_oe_o(g_oe), .gpio_ie_o(g_ie), .gpio_schmitt_o(g_sch), .gpio_slew_o(g_slew),
      .gpio_pullup_o(g_pu), .gpio_pulldown_o(g_pd), .gpio_drive0_o(g_d0), .gpio_drive1_o(g_d1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // A load is "open" while bytes are still wanted; received counts bytes so far.
   bit         mdl_valid = 0;
   bit         open_load = 0;
   bit         commit_pending = 0;
   int         received = 0;
   bit         done_exp = 0;
   logic [7:0] shadow [N];
   logic [7:0] active [N];

   always @(posedge clk) begin
      if (reset) begin
         open_load = 0; commit_pending = 0; received = 0; done_exp = 0;
         for (int p = 0; p < N; p++) begin shadow[p] = RCFG; active[p] = RCFG; end
         mdl_valid = 1;
      end else if (mdl_valid) begin
         done_exp = commit_pending;
         if (commit_pending) begin
            active = shadow;
            commit_pending = 0;
            received = 0;
         end else if (open_load) begin
            if (cfg_abort) begin
               open_load = 0; received = 0;
            end else if (wr_valid) begin
               shadow[received] = wr_data;
               if (received == N - 1) begin open_load = 0; commit_pending = 1; end
               else received++;
            end
         end else if (cfg_start) begin
            open_load = 1; received = 0;
         end
      end
   end

   function automatic logic [63:0] exp_bus(input int b);
      logic [63:0] v = '0;
      for (int p = 0; p < N; p++) v[p] = active[p][b];
      return v;
   endfunction

   // Per-cycle compare, away from the active edge.
   always @(negedge clk) begin
      if (mdl_valid && !reset) begin
         if (cfg_done) done_cnt++;
         chk("wr_ready", 64'(wr_ready), 64'(open_load && !cfg_abort));
         chk("cfg_busy", 64'(cfg_busy), 64'(open_load || commit_pending));
         chk("cfg_done", 64'(cfg_done), 64'(done_exp));
         chk("pad_index", 64'(pad_index), 64'(received));
         chk("gpio_oe", 64'(g_oe), exp_bus(0));
         chk("gpio_ie", 64'(g_ie), exp_bus(1));
         chk("gpio_schmitt", 64'(g_sch), exp_bus(2));
         chk("gpio_slew", 64'(g_slew), exp_bus(3));
         chk("gpio_pullup", 64'(g_pu), exp_bus(4));
         chk("gpio_pulldown", 64'(g_pd), exp_bus(5));
         chk("gpio_drive0", 64'(g_d0), exp_bus(6));
         chk("gpio_drive1", 64'(g_d1), exp_bus(7));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input bit rst, input bit st, input bit ab, input bit v, input logic [7:0] d);
      reset = rst; cfg_start = st; cfg_abort = ab; wr_valid = v; wr_data = d;
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 8'h00);
   endtask

   // Full load of N bytes; byte value is the pad number when use_idx is set.
   task automatic load_all(input bit use_idx, input logic [7:0] val, input bit gappy);
      step(0, 1, 0, 0, 8'h00);
      for (int i = 0; i < N; i++) begin
         if (gappy) step(0, 0, 0, 0, 8'hA5);
         step(0, 0, 0, 1, use_idx ? 8'(i) : val);
      end
   endtask

   function automatic logic [7:0] pad_cfg(input int i);
      return {g_d1[i], g_d0[i], g_pd[i], g_pu[i], g_slew[i], g_sch[i], g_ie[i], g_oe[i]};
   endfunction

   initial begin
      reset = 1; cfg_start = 0; cfg_abort = 0; wr_valid = 0; wr_data = '0;
      // 1. reset state
      step(1, 0, 0, 0, 8'h00);
      step(1, 0, 0, 0, 8'h00);
      chk("rst_ie", 64'(g_ie), ALL1);
      chk("rst_oe", 64'(g_oe), 64'h0);
      chk("rst_drive1", 64'(g_d1), 64'h0);
      chk("rst_ready", 64'(wr_ready), 64'h0);
      chk("rst_busy", 64'(cfg_busy), 64'h0);
      chk("rst_done", 64'(cfg_done), 64'h0);
      step(0, 0, 0, 0, 8'h00);

      // 2. back-to-back load of pad numbers
      done_cnt = 0;
      load_all(1, 8'h00, 0);
      chk("t2_busy_apply", 64'(cfg_busy), 64'h1);
      chk("t2_pre_ie", 64'(g_ie), ALL1);
      step(0, 0, 0, 0, 8'h00);
      chk("t2_done", 64'(cfg_done), 64'h1);
      for (int i = 0; i < N; i++) chk("t2_pad", 64'(pad_cfg(i)), 64'(i));
      idle(3);
      chk("t2_done_once", 64'(done_cnt), 64'h1);

      // 3. gappy load of the same pattern
      step(0, 1, 0, 0, 8'h00);
      step(0, 0, 0, 1, 8'h00);
      step(0, 0, 0, 0, 8'h77);
      chk("t3_idx_gap", 64'(pad_index), 64'h1);
      step(0, 0, 0, 1, 8'h01);
      chk("t3_idx_acc", 64'(pad_index), 64'h2);
      for (int i = 2; i < N; i++) begin
         step(0, 0, 0, 0, 8'h5A);
         step(0, 0, 0, 1, 8'(i));
      end
      idle(2);
      for (int i = 0; i < N; i += 7) chk("t3_pad", 64'(pad_cfg(i)), 64'(i));

      // 4. abort mid-load leaves outputs alone
      load_all(0, 8'hFF, 0);
      idle(2);
      step(0, 1, 0, 0, 8'h00);
      for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 8'h00);
      step(0, 0, 1, 0, 8'h00);
      idle(2);
      chk("t4_oe_ff", 64'(g_oe), ALL1);
      chk("t4_pd_ff", 64'(g_pd), ALL1);
      chk("t4_idx", 64'(pad_index), 64'h0);
      load_all(0, 8'h11, 0);
      idle(2);
      chk("t4_oe", 64'(g_oe), ALL1);
      chk("t4_pu", 64'(g_pu), ALL1);
      chk("t4_ie", 64'(g_ie), 64'h0);
      chk("t4_d1", 64'(g_d1), 64'h0);

      // 5. abort coinciding with the final byte
      done_cnt = 0;
      step(0, 1, 0, 0, 8'h00);
      for (int i = 0; i < N - 1; i++) step(0, 0, 0, 1, 8'h3C);
      step(0, 0, 1, 1, 8'h3C);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 8'hC3);
      chk("t5_no_done", 64'(done_cnt), 64'h0);
      chk("t5_oe", 64'(g_oe), ALL1);
      chk("t5_idle_idx", 64'(pad_index), 64'h0);

      // 6. reset mid-load, then cfg_start mid-load
      step(0, 1, 0, 0, 8'h00);
      for (int i = 0; i < 30; i++) step(0, 0, 0, 1, 8'hEE);
      step(1, 0, 0, 0, 8'h00);
      chk("t6_ie", 64'(g_ie), ALL1);
      chk("t6_oe", 64'(g_oe), 64'h0);
      chk("t6_idx", 64'(pad_index), 64'h0);
      chk("t6_busy", 64'(cfg_busy), 64'h0);
      step(0, 1, 0, 0, 8'h00);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 8'h21);
      step(0, 1, 0, 1, 8'h21);
      chk("t6_restart_idx", 64'(pad_index), 64'd11);
      step(0, 1, 0, 1, 8'h21);
      chk("t6_restart_idx2", 64'(pad_index), 64'd12);
      for (int i = 12; i < N; i++) step(0, 0, 0, 1, 8'h21);
      idle(2);
      chk("t6_final_oe", 64'(g_oe), ALL1);

      // random stream against the model
      for (int c = 0; c < 4000; c++) begin
         step($urandom_range(0, 499) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, 8'($urandom));
      end
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
